// File: rtl/ppu_bg_render.sv
// Background render engine: walks the visible frame pixel by pixel, fetches nametable,
// attribute, pattern and palette data and writes colour codes into the back video buffer.
// Optional left-edge clipping is enabled by defining PPU_BG_LEFT_CLIP_EN.

module ppu_bg_render #(
  parameter int unsigned H_PIX = 256,
  parameter int unsigned V_PIX = 240
) (
  input  logic        i_ppu_clk,
  input  logic        i_ppu_rst,
  input  logic        i_frame_start,
  input  logic        i_bg_en,
  input  logic        i_bg_pt_sel,
`ifdef PPU_BG_LEFT_CLIP_EN
  input  logic        i_bg_left_show,
`endif
  input  logic [1:0]  i_nt_base,
  input  logic [7:0]  i_scroll_x,
  input  logic [7:0]  i_scroll_y,
  output logic [11:0] o_nt_addr,
  input  logic [7:0]  i_nt_rdata,
  output logic [11:0] o_pt_addr,
  input  logic [15:0] i_pt_rdata,
  output logic [4:0]  o_plt_addr,
  input  logic [7:0]  i_plt_rdata,
  output logic [16:0] o_vbuf_waddr,
  output logic        o_vbuf_we,
  output logic [7:0]  o_vbuf_wdata,
  output logic        o_buf_sel,
  output logic        o_busy,
  output logic        o_frame_done
);

  typedef enum logic [2:0] {
    StIdle,
    StNt,
    StAt,
    StPt,
    StLat,
    StPixA,
    StPixW,
    StDone
  } state_e;

  state_e      state_q;
  logic [7:0]  x_q, y_q;
  logic [7:0]  scroll_x_q, scroll_y_q;
  logic [1:0]  nt_base_q;
  logic        bg_en_q;
  logic        pt_sel_q;
  logic [7:0]  tile_q;
  logic [1:0]  attr2_q;
  logic [15:0] pat_q;
  logic        buf_sel_q;
`ifdef PPU_BG_LEFT_CLIP_EN
  logic        left_show_q;
`endif

  logic [8:0]  wx;
  logic [8:0]  wy_raw;
  logic        wy_wrap;
  logic [7:0]  wy;
  logic        nt_v;
  logic [4:0]  cx, cy;
  logic [2:0]  fx, fy;
  logic [11:0] nt_addr, at_addr;
  logic [2:0]  attr_shift;
  logic [1:0]  attr2;
  logic [2:0]  bit_sel;
  logic [1:0]  pix;
  logic        clip;
  logic [4:0]  plt_addr;
  logic        last_x, last_y;
  logic [7:0]  x_inc;
  logic [2:0]  fx_next;
  logic        unused_plt;

  assign unused_plt = ^i_plt_rdata[7:6];

  // World coordinates; a vertical overflow past 240 lines flips to the other nametable row.
  assign wx      = {1'b0, x_q} + {1'b0, scroll_x_q} + {nt_base_q[0], 8'd0};
  assign wy_raw  = {1'b0, y_q} + {1'b0, scroll_y_q};
  assign wy_wrap = (wy_raw >= 9'd240);
  assign wy      = wy_wrap ? 8'(wy_raw - 9'd240) : wy_raw[7:0];
  assign nt_v    = nt_base_q[1] ^ wy_wrap;
  assign cx      = wx[7:3];
  assign fx      = wx[2:0];
  assign cy      = wy[7:3];
  assign fy      = wy[2:0];

  assign nt_addr    = {nt_v, wx[8], cy, cx};
  assign at_addr    = {nt_v, wx[8], 4'b1111, cy[4:2], cx[4:2]};
  assign attr_shift = {cy[1], cx[1], 1'b0};
  assign attr2      = 2'(i_nt_rdata >> attr_shift);

  assign bit_sel = 3'd7 - fx;
  assign pix     = {pat_q[{1'b1, bit_sel}], pat_q[{1'b0, bit_sel}]};

`ifdef PPU_BG_LEFT_CLIP_EN
  assign clip = !left_show_q && (x_q[7:3] == 5'd0);
`else
  assign clip = 1'b0;
`endif

  assign plt_addr = (bg_en_q && !clip && (pix != 2'd0)) ? {1'b0, attr2_q, pix} : 5'd0;

  assign last_x  = (x_q == 8'(H_PIX - 1));
  assign last_y  = (y_q == 8'(V_PIX - 1));
  assign x_inc   = x_q + 8'd1;
  // Fine x of the next pixel; the nametable select bit only shifts wx by 256.
  assign fx_next = x_inc[2:0] + scroll_x_q[2:0];

  always_ff @(posedge i_ppu_clk) begin
    if (i_ppu_rst) begin
      state_q    <= StIdle;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      scroll_x_q <= 8'd0;
      scroll_y_q <= 8'd0;
      nt_base_q  <= 2'd0;
      bg_en_q    <= 1'b0;
      pt_sel_q   <= 1'b0;
      tile_q     <= 8'd0;
      attr2_q    <= 2'd0;
      pat_q      <= 16'd0;
      buf_sel_q  <= 1'b0;
`ifdef PPU_BG_LEFT_CLIP_EN
      left_show_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (i_frame_start) begin
            scroll_x_q <= i_scroll_x;
            scroll_y_q <= i_scroll_y;
            nt_base_q  <= i_nt_base;
            bg_en_q    <= i_bg_en;
            pt_sel_q   <= i_bg_pt_sel;
`ifdef PPU_BG_LEFT_CLIP_EN
            left_show_q <= i_bg_left_show;
`endif
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            state_q    <= i_bg_en ? StNt : StPixA;
          end
        end
        StNt: state_q <= StAt;
        StAt: begin
          tile_q  <= i_nt_rdata;
          state_q <= StPt;
        end
        StPt: begin
          attr2_q <= attr2;
          state_q <= StLat;
        end
        StLat: begin
          pat_q   <= i_pt_rdata;
          state_q <= StPixA;
        end
        StPixA: state_q <= StPixW;
        StPixW: begin
          if (last_x) begin
            if (last_y) begin
              state_q <= StDone;
            end else begin
              x_q     <= 8'd0;
              y_q     <= y_q + 8'd1;
              state_q <= bg_en_q ? StNt : StPixA;
            end
          end else begin
            x_q     <= x_inc;
            state_q <= (bg_en_q && (fx_next == 3'd0)) ? StNt : StPixA;
          end
        end
        StDone: begin
          buf_sel_q <= ~buf_sel_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_nt_addr    = 12'd0;
    o_pt_addr    = 12'd0;
    o_plt_addr   = 5'd0;
    o_vbuf_we    = 1'b0;
    o_vbuf_waddr = 17'd0;
    o_vbuf_wdata = 8'd0;
    case (state_q)
      StNt:   o_nt_addr  = nt_addr;
      StAt:   o_nt_addr  = at_addr;
      StPt:   o_pt_addr  = {pt_sel_q, tile_q, fy};
      StPixA: o_plt_addr = plt_addr;
      StPixW: begin
        o_vbuf_we    = 1'b1;
        o_vbuf_waddr = {~buf_sel_q, y_q, x_q};
        o_vbuf_wdata = {2'b00, i_plt_rdata[5:0]};
      end
      default: ;
    endcase
  end

  assign o_buf_sel    = buf_sel_q;
  assign o_busy       = (state_q != StIdle);
  assign o_frame_done = (state_q == StDone);

endmodule

// File: tb/tb_ppu_bg_render.sv
// Bench for ppu_bg_render on a reduced frame: a per-pixel reference model over VRAM arrays
// checks every write, fetch address and pixel timing; literal cases pin the model.

module tb_ppu_bg_render;

  localparam int unsigned HP   = 32;
  localparam int unsigned VP   = 8;
  localparam int          NPIX = HP * VP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frame_start, bg_en, pt_sel;
  logic [1:0]  nt_base;
  logic [7:0]  scroll_x, scroll_y;
  logic [11:0] o_nt_addr, o_pt_addr;
  logic [7:0]  nt_rdata, plt_rdata;
  logic [15:0] pt_rdata;
  logic [4:0]  o_plt_addr;
  logic [16:0] o_vbuf_waddr;
  logic        o_vbuf_we, o_buf_sel, o_busy, o_frame_done;
  logic [7:0]  o_vbuf_wdata;
  logic        left_show = 1'b1;

  logic [7:0]  nt_mem  [4096];
  logic [15:0] pt_mem  [4096];
  logic [7:0]  plt_mem [32];

  ppu_bg_render #(.H_PIX(HP), .V_PIX(VP)) dut (
    .i_ppu_clk     (clk),
    .i_ppu_rst     (rst),
    .i_frame_start (frame_start),
    .i_bg_en       (bg_en),
    .i_bg_pt_sel   (pt_sel),
`ifdef PPU_BG_LEFT_CLIP_EN
    .i_bg_left_show(left_show),
`endif
    .i_nt_base     (nt_base),
    .i_scroll_x    (scroll_x),
    .i_scroll_y    (scroll_y),
    .o_nt_addr     (o_nt_addr),
    .i_nt_rdata    (nt_rdata),
    .o_pt_addr     (o_pt_addr),
    .i_pt_rdata    (pt_rdata),
    .o_plt_addr    (o_plt_addr),
    .i_plt_rdata   (plt_rdata),
    .o_vbuf_waddr  (o_vbuf_waddr),
    .o_vbuf_we     (o_vbuf_we),
    .o_vbuf_wdata  (o_vbuf_wdata),
    .o_buf_sel     (o_buf_sel),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done)
  );

  // Synchronous VRAM with one cycle of read latency.
  always @(posedge clk) begin
    nt_rdata  <= nt_mem[o_nt_addr];
    pt_rdata  <= pt_mem[o_pt_addr];
    plt_rdata <= plt_mem[o_plt_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state, latched by the bench when it sees a start pulse the DUT must accept.
  int m_scx, m_scy, m_ntb, m_bgen, m_ptsel, m_ls, m_back, m_buf_sel;
  bit in_frame, done_exp;
  int ex, ey, wr_cnt, gap, n0f, fcnt;
  int first_waddr, first_wdata, first_nt, first_at, second_nt, second_x;
  int line0 [16];
  int h_nt [6];
  int h_pt [6];
  int h_plt [6];

  task automatic model_pix(input int x, input int y, output bit fetch, output int nta,
                           output int ata, output int pta, output int plta, output int wd);
    int wx, wy, ntv, cx, fx, cy, fy, tile, attr, attr2, word, p;
    wx  = (x + m_scx + 256 * (m_ntb % 2)) % 512;
    wy  = y + m_scy;
    ntv = m_ntb / 2;
    if (wy >= 240) begin
      wy  = wy - 240;
      ntv = 1 - ntv;
    end
    cx    = (wx / 8) % 32;
    fx    = wx % 8;
    cy    = wy / 8;
    fy    = wy % 8;
    nta   = ntv * 2048 + (wx / 256) * 1024 + cy * 32 + cx;
    ata   = ntv * 2048 + (wx / 256) * 1024 + 960 + (cy / 4) * 8 + cx / 4;
    tile  = int'(nt_mem[nta]);
    attr  = int'(nt_mem[ata]);
    attr2 = (attr >> (((cy / 2) % 2) * 4 + ((cx / 2) % 2) * 2)) % 4;
    pta   = m_ptsel * 2048 + tile * 8 + fy;
    word  = int'(pt_mem[pta]);
    p     = ((word >> (15 - fx)) % 2) * 2 + (word >> (7 - fx)) % 2;
    fetch = (m_bgen != 0) && (x == 0 || fx == 0);
    plta  = (m_bgen != 0 && p != 0) ? attr2 * 4 + p : 0;
`ifdef PPU_BG_LEFT_CLIP_EN
    if (m_ls == 0 && x < 8) plta = 0;
`endif
    wd = int'(plt_mem[plta]) % 64;
  endtask

  always @(negedge clk) begin
    bit fetch;
    int nta, ata, pta, plta, wd;
    for (int i = 5; i > 0; i--) begin
      h_nt[i]  = h_nt[i-1];
      h_pt[i]  = h_pt[i-1];
      h_plt[i] = h_plt[i-1];
    end
    h_nt[0]  = int'(o_nt_addr);
    h_pt[0]  = int'(o_pt_addr);
    h_plt[0] = int'(o_plt_addr);
    if (rst) begin
      in_frame  = 1'b0;
      done_exp  = 1'b0;
      m_buf_sel = 0;
    end else begin
      chk("buf_sel", int'(o_buf_sel), m_buf_sel);
      if (frame_start && !in_frame) begin
        m_scx = int'(scroll_x); m_scy = int'(scroll_y); m_ntb = int'(nt_base);
        m_bgen = int'(bg_en); m_ptsel = int'(pt_sel); m_ls = int'(left_show);
        m_back = 1 - m_buf_sel;
        in_frame = 1'b1; ex = 0; ey = 0; wr_cnt = 0; gap = 0; n0f = 0; fcnt = 0;
      end else if (in_frame) begin
        gap++;
      end
      if (o_frame_done || done_exp) begin
        chk("frame_done", int'(o_frame_done), int'(done_exp));
        if (done_exp) begin
          chk("write_count", wr_cnt, NPIX);
          done_exp  = 1'b0;
          in_frame  = 1'b0;
          m_buf_sel = 1 - m_buf_sel;
        end
      end
      if (o_vbuf_we) begin
        if (!in_frame || wr_cnt >= NPIX) begin
          chk("stray_write", 1, 0);
        end else begin
          model_pix(ex, ey, fetch, nta, ata, pta, plta, wd);
          chk("waddr", int'(o_vbuf_waddr), m_back * 65536 + ey * 256 + ex);
          chk("wdata", int'(o_vbuf_wdata), wd);
          chk("pixel_cycles", gap, fetch ? 6 : 2);
          chk("plt_addr", h_plt[1], plta);
          if (fetch) begin
            chk("nt_addr", h_nt[5], nta);
            chk("at_addr", h_nt[4], ata);
            chk("pt_addr", h_pt[3], pta);
            if (fcnt == 0) begin
              first_nt = h_nt[5];
              first_at = h_nt[4];
            end else if (fcnt == 1) begin
              second_nt = h_nt[5];
              second_x  = ex;
            end
            fcnt++;
          end
          if (wr_cnt == 0) begin
            first_waddr = int'(o_vbuf_waddr);
            first_wdata = int'(o_vbuf_wdata);
          end
          if (ey == 0 && ex < 16) line0[ex] = int'(o_vbuf_wdata);
          if (o_vbuf_wdata == 8'h0F) n0f++;
          ex++;
          if (ex == HP) begin
            ex = 0;
            ey++;
          end
          wr_cnt++;
          gap = 0;
          if (wr_cnt == NPIX) done_exp = 1'b1;
        end
      end
    end
  end

  int bsel_exp = 0;

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) begin
      nt_mem[i] = 8'($urandom);
      pt_mem[i] = 16'($urandom);
    end
    for (int i = 0; i < 32; i++) plt_mem[i] = 8'($urandom);
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 4096; i++) begin
      nt_mem[i] = 8'd0;
      pt_mem[i] = 16'd0;
    end
    for (int i = 0; i < 32; i++) plt_mem[i] = 8'd0;
  endtask

  task automatic run_frame(input bit be, input bit ps, input logic [1:0] ntb,
                           input logic [7:0] sx, input logic [7:0] sy, input int glitch_at);
    int  n;
    bit  glitched, rel;
    bg_en = be; pt_sel = ps; nt_base = ntb; scroll_x = sx; scroll_y = sy;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("busy_after_start", int'(o_busy), 1);
    n = 0; glitched = 1'b0; rel = 1'b0;
    while (!o_frame_done && n < 8000) begin
      @(posedge clk); #1;
      n++;
      if (rel) begin
        frame_start = 1'b0;
        rel = 1'b0;
      end else if (glitch_at > 0 && !glitched && wr_cnt >= glitch_at) begin
        frame_start = 1'b1;
        scroll_x = ~scroll_x;
        scroll_y = scroll_y + 8'd37;
        bg_en    = ~bg_en;
        glitched = 1'b1;
        rel = 1'b1;
      end
    end
    frame_start = 1'b0;
    if (n >= 8000) begin
      chk("frame_timeout", 0, 1);
    end else begin
      bsel_exp = 1 - bsel_exp;
      @(posedge clk); #1;
      chk("busy_after_done", int'(o_busy), 0);
      chk("buf_sel_after_done", int'(o_buf_sel), bsel_exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; frame_start = 1'b0; bg_en = 1'b0; pt_sel = 1'b0;
    nt_base = 2'd0; scroll_x = 8'd0; scroll_y = 8'd0;
    fill_zero();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_we", int'(o_vbuf_we), 0);
    chk("rst_buf_sel", int'(o_buf_sel), 0);
    chk("rst_done", int'(o_frame_done), 0);
    chk("rst_nt_addr", int'(o_nt_addr), 0);
    chk("rst_waddr", int'(o_vbuf_waddr), 0);

    // Backdrop-only frame.
    fill_random();
    plt_mem[0] = 8'h0F;
    run_frame(1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 0);
    chk("bd_first_waddr", first_waddr, 32'h10000);
    chk("bd_first_wdata", first_wdata, 8'h0F);
    chk("bd_all_0f", n0f, NPIX);
    chk("bd_buf_sel", int'(o_buf_sel), 1);

    // Hand-built tile 1 with attribute 0xE4.
    fill_zero();
    nt_mem[0] = 8'h01; nt_mem[12'h3C0] = 8'hE4; pt_mem[8] = 16'hF00F;
    plt_mem[1] = 8'h11; plt_mem[2] = 8'h22; plt_mem[3] = 8'h33;
    run_frame(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 8; i++) chk("tile_line0", line0[i], (i < 4) ? 8'h22 : 8'h11);
    chk("tile_first_nt", first_nt, 12'h000);
    chk("tile_first_at", first_at, 12'h3C0);
    chk("tile_first_waddr", first_waddr, 0);

    // Horizontal scroll into the right nametable.
    fill_random();
    run_frame(1'b1, 1'b0, 2'd1, 8'd3, 8'd0, 0);
    chk("sx_first_nt", first_nt, 12'h400);
    chk("sx_second_x", second_x, 5);
    chk("sx_second_nt", second_nt, 12'h401);

    // Vertical overflow flips to the lower nametable row.
    fill_random();
    run_frame(1'b1, 1'b1, 2'd0, 8'd0, 8'd240, 0);
    chk("sy_first_nt", first_nt, 12'h800);

    // Randomised frames, some with an ignored mid-frame start pulse.
    for (int f = 0; f < 5; f++) begin
      fill_random();
      run_frame((f != 2), 1'($urandom), 2'($urandom), 8'($urandom),
                (f == 3) ? 8'($urandom_range(255, 235)) : 8'($urandom),
                (f % 2 == 0) ? int'($urandom_range(NPIX - 20, 10)) : 0);
    end

`ifdef PPU_BG_LEFT_CLIP_EN
    fill_zero();
    for (int i = 0; i < 4096; i++) nt_mem[i] = 8'h01;
    for (int i = 8; i < 16; i++) pt_mem[i] = 16'hFFFF;
    plt_mem[0] = 8'h0F; plt_mem[7] = 8'h27;
    left_show = 1'b0;
    run_frame(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 8; i++) chk("clip_backdrop", line0[i], 8'h0F);
    chk("clip_x8", line0[8], 8'h27);
    left_show = 1'b1;
`endif

    // Reset in the middle of a frame.
    fill_random();
    bg_en = 1'b1; pt_sel = 1'b0; nt_base = 2'd2; scroll_x = 8'd9; scroll_y = 8'd5;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    n = 0;
    while (wr_cnt < 100 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4000) chk("reset_wait_timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_we", int'(o_vbuf_we), 0);
    chk("midrst_buf_sel", int'(o_buf_sel), 0);
    chk("midrst_done", int'(o_frame_done), 0);
    bsel_exp = 0;

    fill_random();
    run_frame(1'b1, 1'b0, 2'd3, 8'd200, 8'd100, 0);
    chk("post_rst_first_waddr", first_waddr / 65536, 1);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_bg_render.md
Name: ppu_bg_render

Overview:
- Background render engine for the 2C02 core, clocked on the PPU clock domain.
- Walks a 256x240 frame one pixel at a time and drives the VRAM read ports (nametable, attribute, pattern, palette).
- Writes the resulting 8-bit colour codes into the write port of the double-buffered video buffer; the LCD output stage reads them out.
- One frame is rendered per start pulse from the register/config block.

Parameters:
- H_PIX, 256, visible pixels per line
- V_PIX, 240, visible lines per frame

Ports:
- i_ppu_clk  in  1  PPU clock
- i_ppu_rst  in  1  reset, synchronous, active-high
- i_frame_start  in  1  one-cycle pulse; start rendering a frame
- i_bg_en  in  1  background enable (PPUMASK bit 3)
- i_bg_pt_sel  in  1  background pattern table select (PPUCTRL bit 4)
- i_nt_base  in  2  base nametable (PPUCTRL bits 1:0)
- i_scroll_x  in  8  horizontal scroll
- i_scroll_y  in  8  vertical scroll
- o_nt_addr  out  12  nametable/attribute address, offset from $2000
- i_nt_rdata  in  8  nametable data, 1-cycle latency
- o_pt_addr  out  12  pattern word address {pt_sel, tile[7:0], fine_y[2:0]}
- i_pt_rdata  in  16  {plane1[7:0], plane0[7:0]}, 1-cycle latency
- o_plt_addr  out  5  palette RAM address
- i_plt_rdata  in  8  palette data, 1-cycle latency
- o_vbuf_waddr  out  17  {back_buf, y[7:0], x[7:0]}
- o_vbuf_we  out  1  vbuf write strobe
- o_vbuf_wdata  out  8  colour code {2'b00, plt[5:0]}
- o_buf_sel  out  1  front buffer index (last completed frame)
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse when the last pixel is written

Behaviour:

Clocking and reset:
- Single clock i_ppu_clk.
- i_ppu_rst is synchronous and active-high. Asserting it at any point (including mid-frame) aborts the frame.
- Reset values: state IDLE, all outputs 0, o_buf_sel=0.

Frame start:
- i_frame_start is accepted only in IDLE; it is ignored while o_busy=1.
- On acceptance, latch scroll_x, scroll_y, nt_base, bg_en and pt_sel for the whole frame.
- Clear x=0, y=0; assert o_busy.
- Back buffer = ~o_buf_sel.

World coordinates:
- wx = x + scroll_x + 256*nt_base[0], 9 bits, mod 512.
- wy = y + scroll_y, 9 bits. If wy>=240: wy -= 240 once and nt_v = ~nt_base[1]; otherwise nt_v = nt_base[1].
- Coarse x cx = wx[7:3], fine x fx = wx[2:0]; coarse y cy = wy[7:3], fine y fy = wy[2:0].
- Scroll_y values 240-255 give cy 30/31, which deliberately reads attribute bytes as tiles.

Addressing:
- NT address = {nt_v, wx[8], cy, cx}.
- AT address = {nt_v, wx[8], 4'b1111, cy[4:2], cx[4:2]}.
- Attribute pair = attr >> {cy[1], cx[1], 1'b0}, keep [1:0].
- Pixel p = {pt[15-fx], pt[7-fx]}.
- o_plt_addr = (p==0) ? 5'd0 : {1'b0, attr2, p}.

FSM (address driven in a state; data sampled in the next state):
- IDLE: on accepted i_frame_start → NT if bg_en, else PIX_A.
- NT: drive NT address → AT.
- AT: latch tile=i_nt_rdata; drive AT address → PT.
- PT: latch attr2 from i_nt_rdata; drive {pt_sel, tile, fy} → LAT.
- LAT: latch pattern word=i_pt_rdata → PIX_A.
- PIX_A: drive o_plt_addr → PIX_W.
- PIX_W: o_vbuf_we=1, wdata={2'b00, i_plt_rdata[5:0]}, waddr={~o_buf_sel, y, x}. Then:
  - x==255 and y==239 → DONE.
  - x==255, other y: x=0, y++, re-evaluate → NT (or PIX_A if !bg_en).
  - x<255: x++; → NT if the new fx==0 and bg_en, else PIX_A.
- DONE: o_frame_done=1 for one cycle; toggle o_buf_sel; o_busy=0 → IDLE.

Other rules:
- With bg_en=0 latched, no NT/AT/PT fetches occur; every pixel uses plt addr 0 (backdrop). Cost is 2 cycles per pixel.
- A fetch is forced at x==0 of every line regardless of fx.
- Address outputs are 0 in states that do not drive them; o_vbuf_we is high only in PIX_W.
- Exactly 61440 writes per frame; each back-buffer address is written once.

Optional Feature:
- Macro PPU_BG_LEFT_CLIP_EN.
- When defined: adds input i_bg_left_show (1 bit, PPUMASK bit 1), latched at frame start. If it is 0, pixels x<8 use plt addr 0 (fetches still occur).
- When undefined: the port is absent and all pixels render normally.

Test Plan:
- Reset, then i_frame_start with bg_en=0, plt[0]=0x0F → 61440 writes all 0x0F, all addresses {1, y, x}; o_frame_done pulses once; o_buf_sel becomes 1.
- bg_en=1, scroll 0, nt_base 0, NT[0]=0x01, AT[0]=0xE4, pt word at {0, 0x01, 0}=0xF00F, plt[1..3]=0x11/0x22/0x33 → line 0 pixels 0-3 write 0x22, pixels 4-7 write 0x11; o_nt_addr sequence 0x000, 0x3C0.
- scroll_x=3, nt_base=1 → first NT read at x=0 is 0x400; next fetch happens at x=5 with NT address 0x401.
- scroll_y=16, y=230 → wy=6 with nametable flipped: NT address 0x800 | (0<<5) for nt_base=0.
- Pulse i_frame_start mid-frame → ignored, frame completes normally. Then assert i_ppu_rst at pixel 1000 of the next frame → next cycle: IDLE, o_busy=0, o_vbuf_we=0, o_buf_sel=0.
- With PPU_BG_LEFT_CLIP_EN and i_bg_left_show=0 → x=0..7 write backdrop, x=8 writes the tile colour.
